// File: rtl/arbiter_pkg.sv
// arbiter_pkg
// Shared types and constants for the three-requester round-robin arbiter.
//   N_REQ        : number of requesters (fixed at 3)
//   arb_state_t  : arbiter state (IDLE, G1, G2, G3)
//   GNT_*        : one-hot grant encodings driven on granted_req
//   state_to_grant() : maps a state onto its grant vector
package arbiter_pkg;

    localparam int N_REQ = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2,
        G3   = 2'd3
    } arb_state_t;

    localparam logic [N_REQ-1:0] GNT_NONE = 3'b000;
    localparam logic [N_REQ-1:0] GNT_1    = 3'b001;
    localparam logic [N_REQ-1:0] GNT_2    = 3'b010;
    localparam logic [N_REQ-1:0] GNT_3    = 3'b100;

    function automatic logic [N_REQ-1:0] state_to_grant(input arb_state_t s);
        logic [N_REQ-1:0] g;
        case (s)
            G1:      g = GNT_1;
            G2:      g = GNT_2;
            G3:      g = GNT_3;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/arbiter_rr_next_grant.sv
// rr_next_grant
// Combinational next-state logic for the round-robin arbiter.
//   state      : current arbiter state
//   req        : request vector, bit i = requester i+1
//   next_state : state to load at the next clock edge
// From IDLE the search is fixed priority R1 > R2 > R3. From Gk the search
// starts at the requester after k and wraps round to k itself, so the
// requester just served has the lowest priority. No request means IDLE.
module rr_next_grant
    import arbiter_pkg::*;
(
    input  arb_state_t       state,
    input  logic [N_REQ-1:0] req,
    output arb_state_t       next_state
);

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if      (req[0]) next_state = G1;
                else if (req[1]) next_state = G2;
                else if (req[2]) next_state = G3;
                else             next_state = IDLE;
            end
            G1: begin
                if      (req[1]) next_state = G2;
                else if (req[2]) next_state = G3;
                else if (req[0]) next_state = G1;
                else             next_state = IDLE;
            end
            G2: begin
                if      (req[2]) next_state = G3;
                else if (req[0]) next_state = G1;
                else if (req[1]) next_state = G2;
                else             next_state = IDLE;
            end
            G3: begin
                if      (req[0]) next_state = G1;
                else if (req[1]) next_state = G2;
                else if (req[2]) next_state = G3;
                else             next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/arbiter.sv
// arbiter
// Three-requester round-robin arbiter, registered Moore machine.
//   clk         : clock, rising edge active
//   reset       : synchronous active-high reset
//   req[2:0]    : request vector, bit i = requester i+1
//   granted_req : registered grant, one-hot or all-zero
// Optional macro ARBITER_ASSERT_EN compiles in simulation-only checks
// (grant one-hot/zero, grant backed by a request, zero after reset).
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | nothing granted, granted_req = 000
// G1    | requester 1 granted, granted_req = 001
// G2    | requester 2 granted, granted_req = 010
// G3    | requester 3 granted, granted_req = 100
module arbiter
    import arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] granted_req
);

    arb_state_t state_q;
    arb_state_t state_d;

    rr_next_grant u_next (
        .state      (state_q),
        .req        (req),
        .next_state (state_d)
    );

    // The grant register is loaded from the decoded next state so that it
    // always matches state_q while staying a flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            granted_req <= GNT_NONE;
        end else begin
            state_q     <= state_d;
            granted_req <= state_to_grant(state_d);
        end
    end

`ifdef ARBITER_ASSERT_EN
    logic [N_REQ-1:0] chk_req_prev;
    logic             chk_reset_prev;
    logic             chk_armed;

    initial chk_armed = 1'b0;

    always @(posedge clk) begin
        chk_req_prev   <= req;
        chk_reset_prev <= reset;
        chk_armed      <= 1'b1;
    end

    // Checked mid-cycle, once the post-edge values have settled.
    always @(negedge clk) begin
        if (chk_armed) begin
            assert ($onehot0(granted_req))
                else $error("arbiter: grant not one-hot/zero (%b) at %0t", granted_req, $time);
            if (chk_reset_prev) begin
                assert (granted_req == GNT_NONE)
                    else $error("arbiter: grant %b after reset at %0t", granted_req, $time);
            end else begin
                assert ((granted_req & ~chk_req_prev) == GNT_NONE)
                    else $error("arbiter: grant %b without request %b at %0t",
                                granted_req, chk_req_prev, $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_arbiter.sv
module tb_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [2:0] granted_req;

    arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .granted_req (granted_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];
    bit         running   = 1'b1;
    bit         use_model = 1'b0;
    logic [2:0] dir_exp   = 3'b000;
    string      dir_name  = "reset";

    // Reference model: index of the requester last served, -1 when idle.
    // The next grant goes to the first requester found looking round the
    // ring from the one after the last served (idle starts at requester 1).
    int last_idx = -1;

    function automatic int model_next(input int last, input logic [2:0] r);
        int start;
        int idx;
        start = (last < 0) ? 0 : (last + 1) % 3;
        for (int off = 0; off < 3; off++) begin
            idx = (start + off) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int         g;
        logic [2:0] m_exp;
        if (running) begin
            if (reset) g = -1;
            else       g = model_next(last_idx, req);
            last_idx = g;
            m_exp = (g < 0) ? 3'b000 : (3'b001 << g);
            exp_q.push_back(use_model ? m_exp : dir_exp);
        end
    end

    // Monitor: every edge produces a grant, compare it one step later.
    always @(posedge clk) begin
        logic [2:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (granted_req !== e) begin
                failures++;
                $display("FAIL %s: granted_req=%b expected=%b at %0t",
                         use_model ? "random" : dir_name, granted_req, e, $time);
            end
        end
    end

    typedef struct {
        logic       rst;
        logic [2:0] r;
        logic [2:0] e;
        string      name;
    } step_t;

    step_t steps[$];

    task automatic add(input logic rst, input logic [2:0] r,
                       input logic [2:0] e, input string name);
        step_t s;
        s.rst = rst; s.r = r; s.e = e; s.name = name;
        steps.push_back(s);
    endtask

    initial begin
        reset = 1'b1;
        req   = 3'b000;

        add(1, 3'b000, 3'b000, "reset_state");
        add(1, 3'b111, 3'b000, "reset_ignores_req");
        add(0, 3'b001, 3'b001, "single_r1");
        add(0, 3'b010, 3'b010, "single_r2");
        add(0, 3'b100, 3'b100, "single_r3");
        add(0, 3'b000, 3'b000, "idle_from_g3");
        add(0, 3'b111, 3'b001, "all_1");
        add(0, 3'b111, 3'b010, "all_2");
        add(0, 3'b111, 3'b100, "all_3");
        add(0, 3'b111, 3'b001, "all_4");
        add(0, 3'b000, 3'b000, "idle_from_g1");
        add(0, 3'b110, 3'b010, "partial_1");
        add(0, 3'b110, 3'b100, "partial_2");
        add(0, 3'b110, 3'b010, "partial_3");
        add(0, 3'b000, 3'b000, "idle_from_g2");
        add(0, 3'b001, 3'b001, "to_g1");
        add(0, 3'b101, 3'b100, "skip_1");
        add(0, 3'b101, 3'b001, "skip_2");
        add(0, 3'b001, 3'b001, "hold_only_r1");
        add(0, 3'b111, 3'b010, "to_g2");
        add(1, 3'b111, 3'b000, "reset_mid");
        add(0, 3'b111, 3'b001, "release");

        foreach (steps[i]) begin
            reset    = steps[i].rst;
            req      = steps[i].r;
            dir_exp  = steps[i].e;
            dir_name = steps[i].name;
            @(negedge clk);
        end

        use_model = 1'b1;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       req = 3'b111;
                default: req = 3'($urandom_range(0, 7));
            endcase
            @(negedge clk);
        end

        reset = 1'b0;
        req   = 3'b000;
        running = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        checks++;
        if (checks < 400) begin
            failures++;
            $display("FAIL check_count: checks=%0d expected>=400", checks);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbiter.md
# arbiter

Three-requester round-robin arbiter implemented as a registered Moore state machine. Each cycle it grants at most one requester, rotating priority after the last grant so that continuously active requesters are served in turn. It sits between three request sources and a single shared resource, and drives a one-hot grant vector back to the requesters.

## Interface

- Parameters: none. The requester count is fixed at 3.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req` input [2:0]: request vector; bit i is requester i+1 (bit0=R1, bit1=R2, bit2=R3). Level-sensitive, sampled every rising edge.
- `granted_req` output [2:0]: registered grant vector. Either one-hot (bit i grants requester i+1) or all-zero (idle).

## Operation

- States: IDLE, G1, G2, G3. The output is decoded from state only: IDLE=000, G1=001, G2=010, G3=100.
- From IDLE: fixed priority R1 > R2 > R3. If `req`=000, stay in IDLE.
- From Gk: search cyclically starting at the requester after k (k+1, k+2, then k itself) and go to the first one asserting `req`.
  - If only Rk requests, stay in Gk.
  - If `req`=000, go to IDLE.
- No handshake and no minimum hold time. A grant lasts exactly one cycle whenever another requester is pending.
- A grant is never issued to a requester whose `req` bit was low at the sampling edge.
- `req` takes any 3-bit value. All 8 values are legal in every state.
- Unreachable state encodings recover to IDLE on the next edge.

## Timing

- Reset: when `reset`=1 at a rising edge, the state becomes IDLE and `granted_req` becomes 000 after that edge, regardless of `req`. This applies mid-operation too; any grant in progress is dropped.
- On the first edge with `reset`=0, normal arbitration applies to the `req` sampled at that edge.
- Latency: one cycle. `req` sampled at edge n determines `granted_req` valid after edge n, held until edge n+1.
- No combinational path from `req` to `granted_req`.
- With `req`=111 held, grants cycle 001 → 010 → 100 → 001 ... with period 3.
- Dropping a request takes effect at the next edge. The grant moves to the next requester in rotation, or to 000.

## Configuration

- `ARBITER_ASSERT_EN` defined: simulation-only checks are compiled in:
  - `granted_req` is always one-hot or zero.
  - Any granted bit had its `req` bit set at the preceding edge.
  - `granted_req`=000 on the cycle after reset.
  - On violation, report an error with the simulation time.
- `ARBITER_ASSERT_EN` undefined: the checks are absent. Synthesized logic and cycle behaviour are identical either way.

## Structure

- Package `arbiter_pkg`:
  - constant `N_REQ`=3;
  - state enum `arb_state_t` (IDLE, G1, G2, G3);
  - grant encoding constants `GNT_NONE`, `GNT_1`, `GNT_2`, `GNT_3`.
- Sub-module `rr_next_grant`: purely combinational. Takes the current state and `req`; returns the next state using the cyclic search rule.
- The top level holds only the state register, synchronous reset, output decode and the optional assertions.

## Test plan

- Single requests: reset, then `req`=001 → 001; `req`=010 → 010; `req`=100 → 100, each one edge later.
- Idle: `req`=000 from any grant state → 000 after one edge.
- All requesting: from IDLE, `req`=111 held four edges → 001, 010, 100, 001.
- Partial: from IDLE, `req`=110 → 010 then 100, then 010 on the next edge.
- Rotation skip: in G1, `req`=101 → 100, then 001.
- Reset mid-operation: in G2 with `req`=111, assert `reset` for one edge → 000. Release with `req`=111 → 001.
